// File: rtl/issue_ctrl.sv
// Decode-to-execute issue controller: single-entry holding stage with a
// register scoreboard for long-latency results, FENCE drain and flush.
module issue_ctrl #(
    parameter int unsigned MAX_PEND    = 4,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   dec_valid_i,
    output logic                   dec_ready_o,
    input  logic [4:0]             rs1_addr_i,
    input  logic [4:0]             rs2_addr_i,
    input  logic [4:0]             rd_addr_i,
    input  logic                   uses_rs1_i,
    input  logic                   uses_rs2_i,
    input  logic                   reg_write_i,
    input  logic                   long_op_i,
    input  logic                   fence_i,
    output logic                   iss_valid_o,
    input  logic                   iss_ready_i,
    output logic [4:0]             iss_rs1_o,
    output logic [4:0]             iss_rs2_o,
    output logic [4:0]             iss_rd_o,
    output logic                   iss_reg_write_o,
    output logic                   iss_long_op_o,
    input  logic                   wb_valid_i,
    input  logic [4:0]             wb_rd_i,
    input  logic                   flush_i,
    output logic [31:0]            busy_o,
    output logic [3:0]             pend_cnt_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o,
    output logic                   sb_err_o
);

    localparam int unsigned PEND_W = 4;
    localparam int unsigned REG_N  = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;

    logic [4:0]             h_rs1;
    logic [4:0]             h_rs2;
    logic [4:0]             h_rd;
    logic                   h_uses_rs1;
    logic                   h_uses_rs2;
    logic                   h_reg_write;
    logic                   h_long_op;
    logic                   h_fence;

    logic [REG_N-1:0]       busy_q;
    logic [REG_N-1:0]       busy_d;
    logic [PEND_W-1:0]      pend_q;
    logic [PEND_W-1:0]      pend_d;
    logic [STALL_CNT_W-1:0] stall_q;
    logic                   err_q;

    logic                   hazard;
    logic                   fire;
    logic                   accept;
    logic                   issue_set;
    logic                   wb_hit;
    logic                   wb_bad;
    logic                   stall_inc;

    // Hazard check against registered scoreboard state; busy_q[0] is never set.
    always_comb begin
        hazard = 1'b0;
        if (h_uses_rs1 && busy_q[h_rs1]) hazard = 1'b1;
        if (h_uses_rs2 && busy_q[h_rs2]) hazard = 1'b1;
        if (h_reg_write && busy_q[h_rd]) hazard = 1'b1;
        if (h_long_op && h_reg_write && (h_rd != 5'd0) && (pend_q == PEND_W'(MAX_PEND)))
            hazard = 1'b1;
        if (h_fence && (pend_q != '0)) hazard = 1'b1;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d     = state_q;
        iss_valid_o = 1'b0;
        dec_ready_o = 1'b0;
        fire        = 1'b0;
        accept      = 1'b0;

        iss_valid_o = !rst_i && (state_q == HELD) && !hazard && !flush_i;
        fire        = iss_valid_o && iss_ready_i;
        dec_ready_o = !rst_i && !flush_i && ((state_q == EMPTY) || fire);
        accept      = dec_valid_i && dec_ready_o;

        case (state_q)
            EMPTY: if (accept) state_d = HELD;
            HELD:  if (fire && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
        if (flush_i) state_d = EMPTY;
    end

    // Scoreboard update: issue sets, writeback clears, both may land together.
    always_comb begin
        issue_set = fire && h_long_op && h_reg_write && (h_rd != 5'd0);
        wb_hit    = wb_valid_i && busy_q[wb_rd_i];
        wb_bad    = wb_valid_i && !busy_q[wb_rd_i];
        stall_inc = (state_q == HELD) && hazard && !flush_i;

        busy_d = busy_q;
        if (issue_set) busy_d = busy_d | (REG_N'(1) << h_rd);
        if (wb_hit)    busy_d = busy_d & ~(REG_N'(1) << wb_rd_i);
        busy_d[0] = 1'b0;

        pend_d = pend_q;
        case ({issue_set, wb_hit})
            2'b10:   pend_d = pend_q + PEND_W'(1);
            2'b01:   pend_d = pend_q - PEND_W'(1);
            default: pend_d = pend_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_rs1       <= '0;
            h_rs2       <= '0;
            h_rd        <= '0;
            h_uses_rs1  <= 1'b0;
            h_uses_rs2  <= 1'b0;
            h_reg_write <= 1'b0;
            h_long_op   <= 1'b0;
            h_fence     <= 1'b0;
        end else if (accept) begin
            h_rs1       <= rs1_addr_i;
            h_rs2       <= rs2_addr_i;
            h_rd        <= rd_addr_i;
            h_uses_rs1  <= uses_rs1_i;
            h_uses_rs2  <= uses_rs2_i;
            h_reg_write <= reg_write_i;
            h_long_op   <= long_op_i;
            h_fence     <= fence_i;
        end
    end

    // Flush leaves the scoreboard alone: outstanding ops still write back.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q  <= '0;
            pend_q  <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
            if (stall_inc && (stall_q != '1)) stall_q <= stall_q + STALL_CNT_W'(1);
            if (wb_bad) err_q <= 1'b1;
        end
    end

    assign iss_rs1_o       = h_rs1;
    assign iss_rs2_o       = h_rs2;
    assign iss_rd_o        = h_rd;
    assign iss_reg_write_o = h_reg_write;
    assign iss_long_op_o   = h_long_op;
    assign busy_o          = busy_q;
    assign pend_cnt_o      = pend_q;
    assign stall_cnt_o     = stall_q;
    assign sb_err_o        = err_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: expected issues queued at accept time and
// checked by a monitor on every fire; state checks made inline.
module tb_issue_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        dec_valid_i = 1'b0;
    logic        dec_ready_o;
    logic [4:0]  rs1_addr_i = '0;
    logic [4:0]  rs2_addr_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        uses_rs1_i = 1'b0;
    logic        uses_rs2_i = 1'b0;
    logic        reg_write_i = 1'b0;
    logic        long_op_i = 1'b0;
    logic        fence_i = 1'b0;
    logic        iss_valid_o;
    logic        iss_ready_i = 1'b1;
    logic [4:0]  iss_rs1_o;
    logic [4:0]  iss_rs2_o;
    logic [4:0]  iss_rd_o;
    logic        iss_reg_write_o;
    logic        iss_long_op_o;
    logic        wb_valid_i = 1'b0;
    logic [4:0]  wb_rd_i = '0;
    logic        flush_i = 1'b0;
    logic [31:0] busy_o;
    logic [3:0]  pend_cnt_o;
    logic [15:0] stall_cnt_o;
    logic        sb_err_o;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       lo;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    issue_ctrl #(.MAX_PEND(4), .STALL_CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
        .uses_rs1_i(uses_rs1_i), .uses_rs2_i(uses_rs2_i),
        .reg_write_i(reg_write_i), .long_op_i(long_op_i), .fence_i(fence_i),
        .iss_valid_o(iss_valid_o), .iss_ready_i(iss_ready_i),
        .iss_rs1_o(iss_rs1_o), .iss_rs2_o(iss_rs2_o), .iss_rd_o(iss_rd_o),
        .iss_reg_write_o(iss_reg_write_o), .iss_long_op_o(iss_long_op_o),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .flush_i(flush_i),
        .busy_o(busy_o), .pend_cnt_o(pend_cnt_o),
        .stall_cnt_o(stall_cnt_o), .sb_err_o(sb_err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic wb_pulse(input logic [4:0] rd);
        wb_valid_i = 1'b1;
        wb_rd_i    = rd;
        tick();
        wb_valid_i = 1'b0;
    endtask

    // Present one instruction; returns in the cycle after it was accepted.
    task automatic present(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic u1, input logic u2, input logic rw, input logic lo,
                           input logic fe, input bit exp_issue);
        exp_t e;
        rs1_addr_i  = rs1;
        rs2_addr_i  = rs2;
        rd_addr_i   = rd;
        uses_rs1_i  = u1;
        uses_rs2_i  = u2;
        reg_write_i = rw;
        long_op_i   = lo;
        fence_i     = fe;
        dec_valid_i = 1'b1;
        e = '{rs1: rs1, rs2: rs2, rd: rd, rw: rw, lo: lo};
        for (int i = 0; i < 50; i++) begin
            #1;
            if (dec_ready_o) begin
                if (exp_issue) q.push_back(e);
                @(posedge clk_i);
                #1;
                dec_valid_i = 1'b0;
                return;
            end
            @(posedge clk_i);
            #1;
        end
        dec_valid_i = 1'b0;
        checks++;
        errors++;
        $display("FAIL accept_timeout: dec_ready_o never rose for rd=%0d", rd);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i && iss_valid_o && iss_ready_i) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL issue_unexpected: rd=%0d issued, none expected", iss_rd_o);
                end else begin
                    e = q.pop_front();
                    chk("issue_fields",
                        32'({iss_rs1_o, iss_rs2_o, iss_rd_o, iss_reg_write_o, iss_long_op_o}),
                        32'(e));
                end
            end
        end
    endtask

    task automatic run_tests();
        // Reset
        tick(); tick(); settle();
        chk("rst_iss_valid", 32'(iss_valid_o), 0);
        chk("rst_dec_ready", 32'(dec_ready_o), 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_pend", 32'(pend_cnt_o), 0);
        chk("rst_stall", 32'(stall_cnt_o), 0);
        chk("rst_err", 32'(sb_err_o), 0);
        tick();
        rst_i = 1'b0;

        // 1: load x5, dependent add stalls until the cycle after wb
        present(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        present(5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) begin
            settle();
            chk("t1_stalled", 32'(iss_valid_o), 0);
            tick();
        end
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd5;
        settle();
        chk("t1_busy5_set", 32'(busy_o[5]), 1);
        chk("t1_no_bypass", 32'(iss_valid_o), 0);
        tick();
        wb_valid_i = 1'b0;
        settle();
        chk("t1_issue_after_wb", 32'(iss_valid_o), 1);
        chk("t1_busy5_clr", 32'(busy_o[5]), 0);
        chk("t1_stall_cnt", 32'(stall_cnt_o), 4);
        tick();

        // 2: four long ops fill the budget, fifth waits for a writeback
        for (int r = 1; r <= 4; r++)
            present(5'd0, 5'd0, 5'(r), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        present(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        settle();
        chk("t2_pend_full", 32'(pend_cnt_o), 4);
        chk("t2_busy", busy_o, 32'h0000_001E);
        chk("t2_budget_stall", 32'(iss_valid_o), 0);
        tick(); settle();
        chk("t2_budget_stall2", 32'(iss_valid_o), 0);
        wb_pulse(5'd2);
        settle();
        chk("t2_fifth_issues", 32'(iss_valid_o), 1);
        chk("t2_pend_after_wb", 32'(pend_cnt_o), 3);
        tick(); settle();
        chk("t2_pend_net", 32'(pend_cnt_o), 4);
        chk("t2_busy_after", busy_o, 32'h0000_009A);
        wb_pulse(5'd1);
        present(5'd0, 5'd0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd3;
        tick();
        wb_valid_i = 1'b0;
        settle();
        chk("t2_set_clr_same_cycle", 32'(pend_cnt_o), 3);
        chk("t2_busy_set_clr", busy_o, 32'h0000_0190);
        wb_pulse(5'd4);
        wb_pulse(5'd7);
        wb_pulse(5'd8);
        settle();
        chk("t2_drained_pend", 32'(pend_cnt_o), 0);
        chk("t2_drained_busy", busy_o, 0);
        chk("t2_no_err", 32'(sb_err_o), 0);

        // 3: backpressure holds the instruction, release fires once and accepts
        iss_ready_i = 1'b0;
        present(5'd11, 5'd0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        rs1_addr_i  = 5'd0;
        rd_addr_i   = 5'd13;
        uses_rs1_i  = 1'b0;
        reg_write_i = 1'b1;
        long_op_i   = 1'b0;
        dec_valid_i = 1'b1;
        repeat (5) begin
            settle();
            chk("t3_dec_ready_low", 32'(dec_ready_o), 0);
            chk("t3_valid_held", 32'(iss_valid_o), 1);
            chk("t3_rd_stable", 32'(iss_rd_o), 10);
            tick();
        end
        iss_ready_i = 1'b1;
        settle();
        chk("t3_accept_on_fire", 32'(dec_ready_o), 1);
        present(5'd0, 5'd0, 5'd13, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        settle();
        chk("t3_next_rd", 32'(iss_rd_o), 13);
        tick();

        // 4: FENCE waits for both outstanding writebacks
        present(5'd0, 5'd0, 5'd20, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        present(5'd0, 5'd0, 5'd21, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        present(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        settle();
        chk("t4_pend2", 32'(pend_cnt_o), 2);
        chk("t4_fence_stall", 32'(iss_valid_o), 0);
        wb_pulse(5'd20);
        settle();
        chk("t4_pend1", 32'(pend_cnt_o), 1);
        chk("t4_fence_stall2", 32'(iss_valid_o), 0);
        wb_pulse(5'd21);
        settle();
        chk("t4_fence_issues", 32'(iss_valid_o), 1);
        chk("t4_pend0", 32'(pend_cnt_o), 0);
        tick();

        // 5: flush a stalled instruction, scoreboard survives
        present(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        present(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("t5_stalled", 32'(iss_valid_o), 0);
        flush_i = 1'b1;
        #1;
        chk("t5_flush_blocks_accept", 32'(dec_ready_o), 0);
        tick();
        flush_i = 1'b0;
        settle();
        chk("t5_empty_after_flush", 32'(iss_valid_o), 0);
        chk("t5_ready_after_flush", 32'(dec_ready_o), 1);
        chk("t5_busy9_kept", 32'(busy_o[9]), 1);
        chk("t5_pend_kept", 32'(pend_cnt_o), 1);
        wb_pulse(5'd9);
        settle();
        chk("t5_busy_clear", busy_o, 0);
        chk("t5_pend_clear", 32'(pend_cnt_o), 0);
        chk("t5_no_err", 32'(sb_err_o), 0);

        // 6: x0 handling and writeback-error stickiness
        present(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(); settle();
        chk("t6_rd0_busy", busy_o, 0);
        chk("t6_rd0_pend", 32'(pend_cnt_o), 0);
        present(5'd0, 5'd0, 5'd14, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        settle();
        chk("t6_x0_no_stall", 32'(iss_valid_o), 1);
        tick();
        wb_pulse(5'd12);
        settle();
        chk("t6_err_set", 32'(sb_err_o), 1);
        tick(); tick(); settle();
        chk("t6_err_sticky", 32'(sb_err_o), 1);
        chk("t6_err_pend", 32'(pend_cnt_o), 0);

        for (int i = 0; i < 10 && q.size() != 0; i++) tick();
        chk("queue_drained", 32'(q.size()), 0);
    endtask

    initial begin
        fork
            monitor();
            run_tests();
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
Decode-to-execute issue controller for the ButterFly RV32IM core.
- Captures one decoded instruction per handshake and keeps a 32-entry register scoreboard for long-latency results (loads, MUL/DIV).
- Releases the instruction to execute only when it has no RAW/WAW hazard and the outstanding-operation budget allows it.
- Also sequences FENCE (drain) and pipeline flush, and provides a stall performance counter.

Parameters:
MAX_PEND, 4, max outstanding long-latency ops with a pending register write (1..15)
STALL_CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk_i  in  1  core clock
rst_i  in  1  synchronous active-high reset
dec_valid_i  in  1  decoded instruction presented
dec_ready_o  out  1  issue_ctrl accepts the instruction this cycle
rs1_addr_i  in  5  source 1 index
rs2_addr_i  in  5  source 2 index
rd_addr_i  in  5  destination index
uses_rs1_i  in  1  instruction reads rs1
uses_rs2_i  in  1  instruction reads rs2
reg_write_i  in  1  instruction writes rd
long_op_i  in  1  result returns later via wb port (load, MUL/DIV)
fence_i  in  1  instruction is FENCE; must wait for pend_cnt_o==0
iss_valid_o  out  1  held instruction issued to execute
iss_ready_i  in  1  execute accepts
iss_rs1_o, iss_rs2_o, iss_rd_o  out  5 each  held register indices
iss_reg_write_o, iss_long_op_o  out  1 each  held flags
wb_valid_i  in  1  a long op completes
wb_rd_i  in  5  destination of the completing op
flush_i  in  1  discard held instruction (branch/jump redirect)
busy_o  out  32  scoreboard; bit0 always 0
pend_cnt_o  out  4  outstanding long ops
stall_cnt_o  out  STALL_CNT_W  cycles held-but-not-issuable, saturating
sb_err_o  out  1  sticky: writeback to a non-busy or zero register

Behaviour:
- Reset (rst_i=1 at clk edge): state EMPTY, busy_o=0, pend_cnt_o=0, stall_cnt_o=0, sb_err_o=0, held fields=0. Outputs: iss_valid_o=0, dec_ready_o=0 during the reset cycle. Reset mid-operation drops everything, including outstanding scoreboard bits.
- State machine:
  - EMPTY→HELD on dec_valid_i && dec_ready_o; all inputs are registered into the held fields.
  - HELD→EMPTY on fire (iss_valid_o && iss_ready_i) with no new accept.
  - HELD→HELD on fire with a simultaneous accept (back-to-back, no bubble).
  - Any state→EMPTY on flush_i.
- dec_ready_o = !rst_i && !flush_i && (state==EMPTY || fire).
- hazard is computed combinationally from registered busy_o/pend_cnt_o. It is true if any of:
  - uses_rs1 && busy[rs1]
  - uses_rs2 && busy[rs2]
  - reg_write && busy[rd] (WAW)
  - long_op && reg_write && rd!=0 && pend_cnt==MAX_PEND
  - fence && pend_cnt!=0
- Register x0 never creates a hazard.
- iss_valid_o = (state==HELD) && !hazard && !flush_i. There is no same-cycle writeback bypass: a wb clears its busy bit at the edge, and the dependent instruction issues the following cycle at the earliest.
- On fire with long_op && reg_write && rd!=0: set busy[rd] and increment pend_cnt. Long ops with rd==0 or !reg_write do not touch the scoreboard.
- On wb_valid_i with busy[wb_rd]=1: clear busy[wb_rd] and decrement pend_cnt. If wb_rd==0 or busy[wb_rd]=0, the counters are unchanged and sb_err_o is set (cleared only by reset).
- Simultaneous issue-set and wb-clear in one cycle: both apply and pend_cnt is net unchanged. The same register cannot be both set and cleared in one cycle, because the WAW rule forbids it.
- Backpressure: while HELD && !fire, the held fields and iss_*_o are stable.
- stall_cnt_o increments each cycle where state==HELD && hazard && !flush_i, and saturates at all-ones.
- flush_i: held instruction discarded; busy_o/pend_cnt_o preserved because outstanding ops still write back.

Test Plan:
1. Issue load rd=5 (long_op). Next instruction is an add reading rs1=5, with iss_ready_i=1 → iss_valid_o=0 until the cycle after wb_valid_i, wb_rd_i=5. stall_cnt_o equals the number of stall cycles; busy_o[5] is 1 then 0.
2. Four long ops with rd=1..4 issue back-to-back → pend_cnt_o=4, busy_o=0x1E. A fifth long op with rd=7 stalls. wb_rd=2 → the fifth issues the next cycle and pend_cnt_o stays 4.
3. Hold iss_ready_i=0 for 5 cycles with a ready instruction → dec_ready_o=0, iss_rd_o stable. Release → one fire, and the next instruction is accepted in the same cycle.
4. pend_cnt_o=2, then a FENCE is presented → it stalls until both writebacks land, and issues in the cycle after the second.
5. Assert flush_i while HELD and stalled on busy x9 → state EMPTY next cycle, busy_o[9] still 1. A later wb of x9 clears it with no error.
6. Long op with rd=0 → busy_o unchanged and pend_cnt_o=0. Instruction with uses_rs1=1, rs1=0 → no stall. wb_rd_i=12 while not busy → sb_err_o=1 and stays 1.
